// File: rtl/fdiv_frac_arbiter_if.sv
// Requester, response and shared-divider signals of the fraction-divide arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fdiv_frac_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [23:0] req0_a_i;
    logic [23:0] req0_b_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [23:0] req1_a_i;
    logic [23:0] req1_b_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [23:0] rsp_q_o;
    logic        rsp_err_o;

    logic        div_start_o;
    logic [23:0] div_frac_a_o;
    logic [23:0] div_frac_b_o;
    logic        div_done_i;
    logic [23:0] div_frac_q_i;

    logic        busy_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_a_i, req1_b_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_q_o, rsp_err_o,
        input  rsp_ready_i,
        output div_start_o, div_frac_a_o, div_frac_b_o,
        input  div_done_i, div_frac_q_i,
        output busy_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_a_i, req1_b_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_q_o, rsp_err_o,
        output rsp_ready_i,
        input  div_start_o, div_frac_a_o, div_frac_b_o,
        output div_done_i, div_frac_q_i,
        input  busy_o
    );
endinterface

// File: rtl/fdiv_frac_arbiter.sv
// Two-requester arbiter in front of a single shared fraction divider.
// One operation in flight; zero divisors are answered directly without the divider.
module fdiv_frac_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fdiv_frac_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StCapture,
        StResp
    } state_e;

    state_e      state_q;
    logic        prio_q;      // requester that wins a tie next (round-robin only)
    logic [23:0] a_q;
    logic [23:0] b_q;
    logic        id_q;
    logic [23:0] rsp_q_q;
    logic        rsp_err_q;
    logic        rsp_valid_q;
    logic        div_start_q;
    logic        busy_q;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic [23:0] acc_a;
    logic [23:0] acc_b;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                if (RR_EN && prio_q) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = bus.req0_valid_i;
                gnt1 = bus.req1_valid_i;
            end
        end
    end

    assign accept = gnt0 | gnt1;
    assign acc_a  = gnt1 ? bus.req1_a_i : bus.req0_a_i;
    assign acc_b  = gnt1 ? bus.req1_b_i : bus.req0_b_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            a_q         <= 24'h0;
            b_q         <= 24'h0;
            id_q        <= 1'b0;
            rsp_q_q     <= 24'h0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q    <= acc_a;
                        b_q    <= acc_b;
                        id_q   <= gnt1;
                        prio_q <= gnt0;
                        busy_q <= 1'b1;
                        if (acc_b == 24'h0) begin
                            rsp_q_q     <= 24'h0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (bus.div_done_i) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    // Divider quotient register is valid the cycle after its done flag.
                    rsp_q_q     <= bus.div_frac_q_i;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req0_ready_o = gnt0;
    assign bus.req1_ready_o = gnt1;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_id_o     = id_q;
    assign bus.rsp_q_o      = rsp_q_q;
    assign bus.rsp_err_o    = rsp_err_q;
    assign bus.div_start_o  = div_start_q;
    assign bus.div_frac_a_o = a_q;
    assign bus.div_frac_b_o = b_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_fdiv_frac_arbiter.sv
// Scoreboard bench for fdiv_frac_arbiter: a behavioural divider, an accept-driven expected
// queue and a per-cycle monitor; a second fixed-priority instance checks RR_EN=0.
module tb_fdiv_frac_arbiter;

    logic clk;
    logic rst_ni;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    fdiv_frac_arbiter_if bus();
    fdiv_frac_arbiter_if bus_fp();

    fdiv_frac_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    fdiv_frac_arbiter #(.RR_EN(1'b0)) u_dut_fp (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus_fp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event within bound, expected one (cycle %0d)", name, cyc);
    endtask

    // Fraction quotient a/b with the hidden bit at position 23.
    function automatic logic [23:0] ref_q(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] n;
        logic [47:0] q;
        if (b == 24'h0) return 24'h0;
        n = {1'b0, a, 23'h0};
        q = n / {24'h0, b};
        return q[23:0];
    endfunction

    // Behavioural shared divider: done in the 28th cycle after start, result one cycle later.
    logic        dv_busy;
    int          dv_cnt;
    logic [23:0] dv_res;
    logic [23:0] dv_q;
    logic        spurious;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
            dv_res  <= 24'h0;
            dv_q    <= 24'h0;
        end else if (bus.div_start_o) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 0;
            dv_res  <= ref_q(bus.div_frac_a_o, bus.div_frac_b_o);
            dv_q    <= ~ref_q(bus.div_frac_a_o, bus.div_frac_b_o);
        end else if (dv_busy) begin
            if (dv_cnt == 27) begin
                dv_busy <= 1'b0;
                dv_q    <= dv_res;
            end else begin
                dv_cnt <= dv_cnt + 1;
            end
        end
    end

    assign bus.div_done_i      = (dv_busy && dv_cnt == 27) | spurious;
    assign bus.div_frac_q_i    = dv_q;
    assign bus_fp.div_done_i   = 1'b0;
    assign bus_fp.div_frac_q_i = 24'h0;

    typedef struct {
        logic        id;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] q;
        logic        err;
        int          acc_cyc;
    } item_t;

    item_t sb[$];
    logic  gnt_log[$];
    logic  rsp_log[$];
    int    acc_cnt = 0;
    logic  last_acc_id = 1'b0;
    logic  have_last = 1'b0;
    logic  last_gnt = 1'b0;

    // Monitor: expected grant, latency and response contents from the queue.
    initial begin : monitor
        logic  busy_m, v0, v1, e0, e1, w, exp_start, exp_v;
        item_t it;
        item_t nw;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                check("reset_outputs",
                      {bus.rsp_valid_o, bus.rsp_q_o, bus.rsp_err_o, bus.rsp_id_o,
                       bus.div_start_o, bus.div_frac_a_o, bus.div_frac_b_o, bus.busy_o}, '0);
                sb.delete();
                have_last = 1'b0;
            end else begin
                busy_m = (sb.size() != 0);
                check("busy", bus.busy_o, busy_m);
                v0 = bus.req0_valid_i;
                v1 = bus.req1_valid_i;
                e0 = 1'b0;
                e1 = 1'b0;
                if (!busy_m) begin
                    if (v0 && v1) begin
                        w  = have_last ? !last_gnt : 1'b0;
                        e0 = !w;
                        e1 = w;
                    end else begin
                        e0 = v0;
                        e1 = v1;
                    end
                end
                check("req0_ready", bus.req0_ready_o, e0);
                check("req1_ready", bus.req1_ready_o, e1);
                exp_start = 1'b0;
                if (busy_m) begin
                    it = sb[0];
                    exp_start = (it.b != 24'h0) && (cyc == it.acc_cyc + 1);
                    exp_v = (cyc - it.acc_cyc) >= (it.err ? 1 : 31);
                    if (it.b != 24'h0) begin
                        check("div_frac_a", bus.div_frac_a_o, it.a);
                        check("div_frac_b", bus.div_frac_b_o, it.b);
                    end
                    check("rsp_valid", bus.rsp_valid_o, exp_v);
                    if (exp_v) begin
                        check("rsp_id", bus.rsp_id_o, it.id);
                        check("rsp_q", bus.rsp_q_o, it.q);
                        check("rsp_err", bus.rsp_err_o, it.err);
                        if (bus.rsp_ready_i) begin
                            rsp_log.push_back(bus.rsp_id_o);
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    check("rsp_valid_idle", bus.rsp_valid_o, 1'b0);
                end
                check("div_start", bus.div_start_o, exp_start);
                if (e0 || e1) begin
                    nw.id      = e1;
                    nw.a       = e1 ? bus.req1_a_i : bus.req0_a_i;
                    nw.b       = e1 ? bus.req1_b_i : bus.req0_b_i;
                    nw.err     = (nw.b == 24'h0);
                    nw.q       = ref_q(nw.a, nw.b);
                    nw.acc_cyc = cyc;
                    sb.push_back(nw);
                    have_last   = 1'b1;
                    last_gnt    = e1;
                    last_acc_id = e1;
                    acc_cnt++;
                    if (bus.req1_ready_o && v1) gnt_log.push_back(1'b1);
                    else if (bus.req0_ready_o && v0) gnt_log.push_back(1'b0);
                end
            end
        end
    end

    // Fixed-priority instance: both requesters always valid with zero divisors.
    initial begin : fixed_prio
        int fp_gnt;
        bus_fp.req0_valid_i = 1'b0;
        bus_fp.req1_valid_i = 1'b0;
        bus_fp.req0_a_i     = 24'h0;
        bus_fp.req0_b_i     = 24'h0;
        bus_fp.req1_a_i     = 24'h0;
        bus_fp.req1_b_i     = 24'h0;
        bus_fp.rsp_ready_i  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus_fp.req0_valid_i = 1'b1;
        bus_fp.req1_valid_i = 1'b1;
        bus_fp.req0_a_i     = 24'h900000;
        bus_fp.req1_a_i     = 24'hA00000;
        fp_gnt = 0;
        for (int i = 0; i < 100 && fp_gnt < 4; i++) begin
            @(negedge clk);
            if (bus_fp.req0_ready_o || bus_fp.req1_ready_o) begin
                check("fp_grant_id", bus_fp.req1_ready_o, 1'b0);
                fp_gnt++;
            end
            if (bus_fp.rsp_valid_o)
                check("fp_rsp", {bus_fp.rsp_id_o, bus_fp.rsp_q_o, bus_fp.rsp_err_o},
                      {1'b0, 24'h0, 1'b1});
        end
        if (fp_gnt < 4) fail_timeout("fp_grants");
        @(posedge clk);
        #1;
        bus_fp.req0_valid_i = 1'b0;
        bus_fp.req1_valid_i = 1'b0;
    end

    task automatic set_req(input logic r, input logic v, input logic [23:0] a,
                           input logic [23:0] b);
        if (r) begin
            bus.req1_valid_i = v;
            bus.req1_a_i     = a;
            bus.req1_b_i     = b;
        end else begin
            bus.req0_valid_i = v;
            bus.req0_a_i     = a;
            bus.req0_b_i     = b;
        end
    endtask

    task automatic rand_data(output logic [23:0] a, output logic [23:0] b);
        a = {1'b1, 23'($urandom)};
        b = ($urandom_range(0, 5) == 0) ? 24'h0 : {1'b1, 23'($urandom)};
    endtask

    // Waits for requester r to be accepted after acc_cnt == base, then drops its valid.
    task automatic wait_acc(input logic r, input int base);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (acc_cnt != base && last_acc_id == r) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (r) bus.req1_valid_i = 1'b0;
        else bus.req0_valid_i = 1'b0;
        if (!ok) fail_timeout("accept");
    endtask

    task automatic issue(input logic r, input logic [23:0] a, input logic [23:0] b);
        int base;
        base = acc_cnt;
        set_req(r, 1'b1, a, b);
        wait_acc(r, base);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) fail_timeout("wait_idle");
    endtask

    initial begin : stimulus
        logic [23:0] a, b;
        logic        exp_rr [4];
        int          base, seen, target;
        bit          ok;
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_ni          = 1'b0;
        spurious        = 1'b0;
        bus.rsp_ready_i = 1'b1;
        set_req(1'b0, 1'b0, 24'h0, 24'h0);
        set_req(1'b1, 1'b0, 24'h0, 24'h0);
        repeat (4) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Nominal divide, then a zero divisor from requester 1.
        issue(1'b0, 24'hC00000, 24'h800000);
        wait_idle();
        issue(1'b1, 24'hABCDEF, 24'h000000);
        wait_idle();

        // Both requesters continuously valid: round-robin alternation.
        gnt_log.delete();
        rsp_log.delete();
        base = acc_cnt;
        set_req(1'b0, 1'b1, 24'hE00000, 24'h900000);
        set_req(1'b1, 1'b1, 24'h880000, 24'hF00000);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (acc_cnt - base >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        if (!ok) fail_timeout("rr_four_ops");
        wait_idle();
        check("rr_grant_count", gnt_log.size(), 4);
        check("rr_rsp_count", rsp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_log.size()) check("rr_grant_seq", gnt_log[i], exp_rr[i]);
            if (i < rsp_log.size()) check("rr_rsp_id_seq", rsp_log[i], exp_rr[i]);
        end

        // Consumer stalls 10 cycles in RESP while requester 1 waits.
        bus.rsp_ready_i = 1'b0;
        issue(1'b0, 24'hF00000, 24'hC00000);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (bus.rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("stall_rsp_valid");
        #1;
        base = acc_cnt;
        set_req(1'b1, 1'b1, 24'h812345, 24'h8ABCDE);
        repeat (10) @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        wait_acc(1'b1, base);
        wait_idle();

        // Reset while the divider is running, then a fresh request.
        issue(1'b0, 24'hD00000, 24'hA00000);
        repeat (10) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        issue(1'b0, 24'hB00000, 24'h880000);
        wait_idle();

        // Stray divider done while idle.
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with drops, stalls and stray done pulses in RESP/IDLE.
        seen   = acc_cnt;
        target = acc_cnt + 40;
        for (int c = 0; c < 4000 && acc_cnt < target; c++) begin
            @(posedge clk);
            #1;
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            spurious = (bus.rsp_valid_o || !bus.busy_o) && ($urandom_range(0, 7) == 0);
            for (int r = 0; r < 2; r++) begin
                logic cur;
                cur = (r == 1) ? bus.req1_valid_i : bus.req0_valid_i;
                if (acc_cnt != seen && last_acc_id == 1'(r)) begin
                    rand_data(a, b);
                    set_req(1'(r), 1'($urandom_range(0, 1)), a, b);
                end else if (cur && $urandom_range(0, 7) == 0) begin
                    rand_data(a, b);
                    set_req(1'(r), 1'b0, a, b);
                end else if (!cur && $urandom_range(0, 2) == 0) begin
                    rand_data(a, b);
                    set_req(1'(r), 1'b1, a, b);
                end
            end
            seen = acc_cnt;
        end
        if (acc_cnt < target) fail_timeout("random_ops");
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        spurious         = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
